// File: rtl/hazard_control_unit_pkg.sv
// Shared types, stall-length constants and the register-match helper
// for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

  // Bubbles needed when a branch in ID depends on a load / ALU result in EX.
  localparam int LOAD_BRANCH_STALLS = 2;
  localparam int ALU_BRANCH_STALLS  = 1;

  // A producer register matches when it is not x0 and feeds a source
  // operand that the ID instruction actually reads.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2,
                                     input logic       use1,
                                     input logic       use2);
    return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = pipeline side, slave = hazard controller side.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Rs1;
  logic [4:0]       ID_Rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic             ID_is_branch;
  logic             ID_branch_taken;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       EX_Rd;
  logic             MEM_MemRead;
  logic [4:0]       MEM_Rd;
  logic             dmem_busy;

  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_is_branch,
           ID_branch_taken, EX_RegWrite, EX_MemRead, EX_Rd,
           MEM_MemRead, MEM_Rd, dmem_busy,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze,
           stall_cycles, flush_count
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_is_branch,
           ID_branch_taken, EX_RegWrite, EX_MemRead, EX_Rd,
           MEM_MemRead, MEM_Rd, dmem_busy,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_control_unit_detect.sv
// Pure combinational stall-demand encoder: how many bubbles the ID
// instruction needs before its operands can be forwarded.
module hazard_detect_comb
  import hazard_pkg::*;
(
  input  logic [4:0] ID_Rs1,
  input  logic [4:0] ID_Rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic       ID_is_branch,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rd,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_Rd,
  output logic [1:0] need
);

  logic m_ex;
  logic m_mem;

  assign m_ex  = reg_match(EX_Rd,  ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2);
  assign m_mem = reg_match(MEM_Rd, ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2);

  // Priority-ordered demand: longest branch dependency wins.
  always_comb begin
    need = '0;
    if (ID_is_branch && EX_MemRead && m_ex)
      need = 2'(LOAD_BRANCH_STALLS);
    else if (ID_is_branch && EX_RegWrite && m_ex)
      need = 2'(ALU_BRANCH_STALLS);
    else if (ID_is_branch && MEM_MemRead && m_mem)
      need = 2'(ALU_BRANCH_STALLS);
    else if (EX_MemRead && m_ex)
      need = 2'd1;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: stall/flush FSM, data-memory freeze and
// stall/flush performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STALL_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  hazard_control_unit_if.slave hz
);

  hz_state_t          state, state_nxt;
  hz_state_t          ret_state, ret_state_nxt;
  hz_state_t          eff_state;
  logic [STALL_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;
  logic [1:0]         need;

  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze;

  hazard_detect_comb u_detect (
    .ID_Rs1      (hz.ID_Rs1),
    .ID_Rs2      (hz.ID_Rs2),
    .ID_uses_rs1 (hz.ID_uses_rs1),
    .ID_uses_rs2 (hz.ID_uses_rs2),
    .ID_is_branch(hz.ID_is_branch),
    .EX_RegWrite (hz.EX_RegWrite),
    .EX_MemRead  (hz.EX_MemRead),
    .EX_Rd       (hz.EX_Rd),
    .MEM_MemRead (hz.MEM_MemRead),
    .MEM_Rd      (hz.MEM_Rd),
    .need        (need)
  );

  // On the release cycle of a freeze, act as the saved state; `remaining`
  // itself is never touched while frozen, so it doubles as the saved count.
  always_comb begin
    eff_state = state;
    if (state == FREEZE && !hz.dmem_busy)
      eff_state = ret_state;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    remaining_nxt = remaining;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pipe_freeze   = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz.dmem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_nxt   = FREEZE;
      if (state != FREEZE)
        ret_state_nxt = state;
    end else begin
      case (eff_state)
        RUN: begin
          if (need == 2'd0) begin
            if_id_flush = hz.ID_branch_taken;
            state_nxt   = RUN;
          end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (need > 2'd1) begin
              state_nxt     = STALL;
              remaining_nxt = STALL_W'(need - 2'd1);
            end else begin
              state_nxt = RUN;
            end
          end
        end
        STALL: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (remaining <= STALL_W'(1)) begin
            remaining_nxt = '0;
            state_nxt     = RUN;
          end else begin
            remaining_nxt = remaining - STALL_W'(1);
            state_nxt     = STALL;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State, saved return state and remaining-stall register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Performance counters; freeze cycles assert neither flush so never count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_ex_flush) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.IF_ID_write  = if_id_write;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.pipe_freeze  = pipe_freeze;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with an expected-output scoreboard.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int CNT_W = 32;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze}
  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_TAKEN = 5'b11100;
  localparam logic [4:0] O_FRZ   = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] outs;
    logic       in_rst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_control_unit #(.CNT_W(CNT_W), .STALL_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.ID_Rs1 = 5'd0;          bus.ID_Rs2 = 5'd0;
    bus.ID_uses_rs1 = 1'b0;     bus.ID_uses_rs2 = 1'b0;
    bus.ID_is_branch = 1'b0;    bus.ID_branch_taken = 1'b0;
    bus.EX_RegWrite = 1'b0;     bus.EX_MemRead = 1'b0;    bus.EX_Rd = 5'd0;
    bus.MEM_MemRead = 1'b0;     bus.MEM_Rd = 5'd0;        bus.dmem_busy = 1'b0;
  endtask

  // Push expectation for the current cycle, then sample 1 time unit later
  // (well clear of the rising edge) and compare against the popped entry.
  task automatic expect_out(input string tag, input logic [4:0] outs);
    exp_t e;
    logic [4:0] obs;
    sb.push_back('{tag: tag, outs: outs, in_rst: rst});
    #1;
    e = sb.pop_front();
    if (e.in_rst) begin
      m_stall = '0;
      m_flush = '0;
    end
    obs = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_flush, bus.pipe_freeze};
    checks++;
    assert (obs === e.outs) else begin
      errors++;
      $error("FAIL %s outs: observed %b expected %b", e.tag, obs, e.outs);
    end
    checks++;
    assert (bus.stall_cycles === m_stall) else begin
      errors++;
      $error("FAIL %s stall_cycles: observed %0d expected %0d", e.tag, bus.stall_cycles, m_stall);
    end
    checks++;
    assert (bus.flush_count === m_flush) else begin
      errors++;
      $error("FAIL %s flush_count: observed %0d expected %0d", e.tag, bus.flush_count, m_flush);
    end
    if (!e.in_rst) begin
      if (e.outs[1]) m_stall = m_stall + 1;
      if (e.outs[2]) m_flush = m_flush + 1;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    expect_out("reset", O_RST);

    @(negedge clk); rst = 1'b0; idle();
    expect_out("post_reset_idle", O_NORM);

    // Load-use: lw x5 in EX, add reads x5.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd5;
    bus.ID_Rs1 = 5'd5; bus.ID_uses_rs1 = 1'b1;
    expect_out("load_use", O_STALL);
    @(negedge clk); bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_Rd = 5'd0;
    expect_out("load_use_release", O_NORM);

    // Load -> branch on rs2, taken ignored during both stall cycles.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd7;
    bus.ID_is_branch = 1'b1; bus.ID_Rs2 = 5'd7; bus.ID_uses_rs2 = 1'b1;
    bus.ID_branch_taken = 1'b1;
    expect_out("load_branch_c1", O_STALL);
    @(negedge clk);
    expect_out("load_branch_c2", O_STALL);

    // Taken branch, no hazard.
    @(negedge clk); idle();
    bus.ID_is_branch = 1'b1; bus.ID_branch_taken = 1'b1;
    expect_out("taken_branch", O_TAKEN);
    @(negedge clk); idle();
    expect_out("after_taken", O_NORM);

    // ALU result in EX feeding a branch: single bubble, stays in RUN.
    @(negedge clk); idle();
    bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd9;
    bus.ID_is_branch = 1'b1; bus.ID_Rs1 = 5'd9; bus.ID_uses_rs1 = 1'b1;
    bus.ID_branch_taken = 1'b1;
    expect_out("alu_branch", O_STALL);
    // Load in MEM feeding the same branch.
    @(negedge clk); bus.EX_RegWrite = 1'b0; bus.EX_Rd = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_Rd = 5'd9;
    expect_out("mem_load_branch", O_STALL);
    @(negedge clk); bus.MEM_MemRead = 1'b0; bus.MEM_Rd = 5'd0;
    expect_out("branch_resolved", O_TAKEN);

    // x0 never matches.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd0;
    bus.ID_Rs1 = 5'd0; bus.ID_uses_rs1 = 1'b1;
    expect_out("x0_no_match", O_NORM);
    // Unused rs2 does not match.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd3;
    bus.ID_Rs2 = 5'd3; bus.ID_uses_rs2 = 1'b0;
    bus.ID_Rs1 = 5'd4; bus.ID_uses_rs1 = 1'b1;
    expect_out("unused_rs2", O_NORM);
    // ALU producer feeding a non-branch is forwarded, no stall.
    @(negedge clk); idle();
    bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd6;
    bus.ID_Rs1 = 5'd6; bus.ID_uses_rs1 = 1'b1;
    expect_out("alu_forwarded", O_NORM);

    // Freeze in the middle of a load->branch stall.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd7;
    bus.ID_is_branch = 1'b1; bus.ID_Rs2 = 5'd7; bus.ID_uses_rs2 = 1'b1;
    expect_out("frz_stall_enter", O_STALL);
    @(negedge clk); bus.dmem_busy = 1'b1;
    expect_out("frz_c1", O_FRZ);
    @(negedge clk);
    expect_out("frz_c2", O_FRZ);
    @(negedge clk);
    expect_out("frz_c3", O_FRZ);
    @(negedge clk); bus.dmem_busy = 1'b0;
    expect_out("frz_release_stall", O_STALL);
    @(negedge clk); idle();
    expect_out("frz_back_to_run", O_NORM);

    // Freeze suppresses a taken-branch flush; flush fires on release.
    @(negedge clk); idle();
    bus.ID_is_branch = 1'b1; bus.ID_branch_taken = 1'b1; bus.dmem_busy = 1'b1;
    expect_out("frz_taken", O_FRZ);
    @(negedge clk); bus.dmem_busy = 1'b0;
    expect_out("frz_taken_release", O_TAKEN);
    @(negedge clk); idle();
    expect_out("idle_after_release", O_NORM);

    // Asynchronous reset while in STALL.
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_Rd = 5'd7;
    bus.ID_is_branch = 1'b1; bus.ID_Rs2 = 5'd7; bus.ID_uses_rs2 = 1'b1;
    expect_out("rst_stall_enter", O_STALL);
    @(negedge clk);
    #2 rst = 1'b1;
    expect_out("async_reset_mid_stall", O_RST);
    @(negedge clk); rst = 1'b0; idle();
    expect_out("post_async_reset", O_NORM);
    @(negedge clk);
    expect_out("post_async_reset_idle", O_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. Branches and JALR are resolved in ID.
- Sits beside the ALU, memory and branch forwarding units. It covers the hazards forwarding cannot cover:
  - load-use;
  - branch-in-ID operand not yet produced;
  - taken-branch wrong-path fetch;
  - data-memory wait.
- Drives PC, IF/ID, ID/EX and whole-pipe write enables and flushes, plus stall/flush performance counters.

Parameters:
CNT_W, 32, width of performance counters
STALL_W, 2, width of remaining-stall counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ID_Rs1  in  5  rs1 of instruction in ID
ID_Rs2  in  5  rs2 of instruction in ID
ID_uses_rs1  in  1  ID instruction reads rs1
ID_uses_rs2  in  1  ID instruction reads rs2
ID_is_branch  in  1  ID instruction is branch/JALR (operands consumed in ID)
ID_branch_taken  in  1  branch ALU redirects PC this cycle
EX_RegWrite  in  1  EX instruction writes Rd
EX_MemRead  in  1  EX instruction is a load
EX_Rd  in  5  EX destination
MEM_MemRead  in  1  MEM instruction is a load
MEM_Rd  in  5  MEM destination
dmem_busy  in  1  data memory not ready; pipeline must freeze
PC_write  out  1  PC register enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  replace IF/ID contents with NOP
ID_EX_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
stall_cycles  out  CNT_W  cycles spent in hazard stall
flush_count  out  CNT_W  taken-branch flushes issued

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high. Everything else is synchronous to rising `clk`.

Matches and stall demand:
- Match rule: `m(Rd) = (Rd != 0) && ((ID_uses_rs1 && Rd == ID_Rs1) || (ID_uses_rs2 && Rd == ID_Rs2))`.
- Stall demand `need`, evaluated in RUN. The highest applicable rule wins:
  - `ID_is_branch && EX_MemRead && m(EX_Rd)`: need = 2.
  - `ID_is_branch && EX_RegWrite && m(EX_Rd)`: need = 1.
  - `ID_is_branch && MEM_MemRead && m(MEM_Rd)`: need = 1.
  - `EX_MemRead && m(EX_Rd)` (load-use, non-branch): need = 1.
  - Otherwise: need = 0.

States:
- RUN
- STALL: holds `remaining`, a STALL_W-bit counter.
- FREEZE: remembers the return state and its `remaining`.

Outputs by condition (combinational from state and inputs):
- RUN, need = 0:
  - PC_write = 1, IF_ID_write = 1, ID_EX_flush = 0.
  - IF_ID_flush = ID_branch_taken.
- RUN, need > 0:
  - PC_write = 0, IF_ID_write = 0, ID_EX_flush = 1, IF_ID_flush = 0.
  - ID_branch_taken is ignored, because operands are stale.
  - If need = 2, next state is STALL with remaining = 1; otherwise stay in RUN.
- STALL:
  - Same outputs as RUN with need > 0.
  - remaining decrements each cycle; when it reaches 0 → RUN.
  - The branch is then re-evaluated in RUN with forwarded operands.
- dmem_busy = 1 (any state):
  - pipe_freeze = 1, PC_write = 0, IF_ID_write = 0.
  - ID_EX_flush = 0, IF_ID_flush = 0.
  - The state goes to FREEZE; `remaining` does not decrement.
- dmem_busy falling: return to the saved state with the saved `remaining`. Stalls are not re-evaluated in that cycle.
- pipe_freeze = 0 whenever dmem_busy = 0.

Counters (wrap modulo 2^CNT_W):
- stall_cycles increments on every cycle with ID_EX_flush = 1.
- flush_count increments on every cycle with IF_ID_flush = 1.
- Freeze cycles count toward neither.

Reset (asserted, including mid-stall or mid-freeze):
- State → RUN, remaining = 0, counters = 0.
- While rst is high: PC_write = 0, IF_ID_write = 0, IF_ID_flush = 1, ID_EX_flush = 1, pipe_freeze = 0.
- Normal outputs are produced in the first cycle after deassertion.

Rd = x0 never matches. Latency: zero-cycle (combinational) response to hazards; only the STALL sequence is registered.

Decomposition:
- Shared package `hazard_pkg`:
  - state enum `hz_state_t` {RUN, STALL, FREEZE};
  - constants LOAD_BRANCH_STALLS = 2 and ALU_BRANCH_STALLS = 1;
  - function `reg_match(rd, rs1, rs2, use1, use2)`.
- One natural sub-module: `hazard_detect_comb`, the pure combinational `need` encoder. The FSM, counters and output muxing stay in the top module.

Test Plan:
- Load-use: EX lw x5 (EX_MemRead=1, EX_Rd=5); ID add reads rs1=5 → one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle with EX_Rd=0 → RUN; stall_cycles=1.
- Load→branch: EX lw x7; ID beq with rs2=7 → 2 stall cycles (STALL entered with remaining=1) → RUN; stall_cycles=2; ID_branch_taken=1 during stall produces no IF_ID_flush.
- Taken branch, no hazard: ID_is_branch=1, ID_branch_taken=1 → IF_ID_flush=1 for 1 cycle, PC_write=1; flush_count=1.
- x0 / unused operand: EX lw x0 with ID_Rs1=0; EX lw x3 with ID_Rs2=3 but ID_uses_rs2=0 → no stall in either case.
- Freeze during STALL: dmem_busy=1 for 3 cycles in STALL (remaining=1) → pipe_freeze=1 for 3 cycles, counters unchanged; on release the remaining stall cycle executes → RUN.
- Reset mid-STALL: assert rst asynchronously → all flush outputs 1 immediately, state RUN, counters 0; after release, need=0 gives PC_write=1.
